// File: rtl/alu_main.sv
// alu_main: accumulator-style 8-bit ALU with a one-hot mode request FSM and one-hot op select
module alu_main #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         on,
  input  logic [2:0]   in_sel,
  input  logic [W-1:0] num1,
  input  logic [W-1:0] num2,
  output logic [W-1:0] final1,
  output logic [W-1:0] final2,
  input  logic [6:0]   out_sel,
  output logic [W-1:0] out,
  output logic [1:0]   currState,
  output logic [1:0]   nextState
);
  typedef enum logic [1:0] {OFF = 2'b00, CLR = 2'b01, LD = 2'b10, PER = 2'b11} state_t;
  state_t cs, ns;
  logic [2*W-1:0] prod;
  logic [W-1:0] result;
  logic active;
  // next state by priority, operand mux keyed on next state, and one-hot op decode
  always_comb begin
    ns = !on ? OFF : in_sel[2] ? CLR : in_sel[1] ? LD : in_sel[0] ? PER : cs;
    active = ns == LD || ns == PER;
    final1 = ns == LD ? num1 : ns == PER ? out : '0;
    final2 = active ? num2 : '0;
    prod = {{W{1'b0}}, final1} * {{W{1'b0}}, final2};
    result = out_sel == 7'b1000000 ? prod[W-1:0] :
             out_sel == 7'b0100000 ? final1 + final2 :
             out_sel == 7'b0010000 ? final1 - final2 :
             out_sel == 7'b0001000 ? final1 & final2 :
             out_sel == 7'b0000100 ? final1 | final2 :
             out_sel == 7'b0000010 ? final1 ^ final2 :
             out_sel == 7'b0000001 ? ~final1 : '0;
  end
  // state and accumulator update; off holds, clear zeroes
  always_ff @(posedge clk) begin
    if (!rst) begin
      cs <= OFF;
      out <= '0;
    end else begin
      cs <= ns;
      out <= active ? result : ns == CLR ? '0 : out;
    end
  end
  assign currState = cs;
  assign nextState = ns;
endmodule

// File: tb/tb_alu_main.sv
// tb_alu_main: directed table-driven check of alu_main
module tb_alu_main;
  logic clk = 1'b0, rst, on;
  logic [2:0] in_sel;
  logic [7:0] num1, num2, final1, final2, out;
  logic [6:0] out_sel;
  logic [1:0] currState, nextState;
  int n_cmp = 0, n_bad = 0;

  alu_main #(.W(8)) dut (
    .clk(clk), .rst(rst), .on(on), .in_sel(in_sel), .num1(num1), .num2(num2),
    .final1(final1), .final2(final2), .out_sel(out_sel), .out(out),
    .currState(currState), .nextState(nextState)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] MUL = 7'b1000000, ADD = 7'b0100000, SUB = 7'b0010000,
                         AND = 7'b0001000, OR = 7'b0000100, XOR = 7'b0000010,
                         NOT = 7'b0000001, NONE = 7'b0000000;

  typedef struct {
    logic rst, on;
    logic [2:0] in_sel;
    logic [6:0] op;
    logic [7:0] n1, n2, f1, f2, o;
    logic [1:0] ns, cs;
  } vec_t;
  vec_t v[$];

  task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got 0x%02h expected 0x%02h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    rst = t.rst; on = t.on; in_sel = t.in_sel; out_sel = t.op; num1 = t.n1; num2 = t.n2;
    #1;
    chk("final1", idx, final1, t.f1);
    chk("final2", idx, final2, t.f2);
    chk("nextState", idx, {6'b0, nextState}, {6'b0, t.ns});
    @(posedge clk);
    #1;
    chk("out", idx, out, t.o);
    chk("currState", idx, {6'b0, currState}, {6'b0, t.cs});
  endtask

  initial begin
    //                rst   on   in_sel  op    n1     n2     f1     f2     out    ns     cs
    v.push_back('{1'b0, 1'b1, 3'b010, MUL,  8'd1,  8'd2,  8'd1,  8'd2,  8'h00, 2'b10, 2'b00});
    v.push_back('{1'b1, 1'b1, 3'b010, MUL,  8'd1,  8'd2,  8'd1,  8'd2,  8'd2,  2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b010, MUL,  8'd3,  8'd2,  8'd3,  8'd2,  8'd6,  2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b010, MUL,  8'h57, 8'h1A, 8'h57, 8'h1A, 8'hD6, 2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b010, MUL,  8'd1,  8'd3,  8'd1,  8'd3,  8'd3,  2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b001, MUL,  8'd99, 8'd4,  8'd3,  8'd4,  8'd12, 2'b11, 2'b11});
    v.push_back('{1'b1, 1'b1, 3'b001, MUL,  8'd99, 8'd4,  8'd12, 8'd4,  8'd48, 2'b11, 2'b11});
    v.push_back('{1'b1, 1'b1, 3'b010, ADD,  8'd200,8'd100,8'd200,8'd100,8'd44, 2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b010, SUB,  8'd2,  8'd4,  8'd2,  8'd4,  8'hFE, 2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b010, AND,  8'h57, 8'h1A, 8'h57, 8'h1A, 8'h12, 2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b010, OR,   8'h57, 8'h1A, 8'h57, 8'h1A, 8'h5F, 2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b010, XOR,  8'h57, 8'h1A, 8'h57, 8'h1A, 8'h4D, 2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b010, NOT,  8'h57, 8'h1A, 8'h57, 8'h1A, 8'hA8, 2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b010, NONE, 8'h57, 8'h1A, 8'h57, 8'h1A, 8'h00, 2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b010, 7'b0011000, 8'h57, 8'h1A, 8'h57, 8'h1A, 8'h00, 2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b010, MUL,  8'd3,  8'd4,  8'd3,  8'd4,  8'd12, 2'b10, 2'b10});
    v.push_back('{1'b1, 1'b0, 3'b001, MUL,  8'd7,  8'd5,  8'd0,  8'd0,  8'd12, 2'b00, 2'b00});
    v.push_back('{1'b1, 1'b1, 3'b001, MUL,  8'd7,  8'd2,  8'd12, 8'd2,  8'd24, 2'b11, 2'b11});
    v.push_back('{1'b1, 1'b1, 3'b100, MUL,  8'd7,  8'd2,  8'd0,  8'd0,  8'd0,  2'b01, 2'b01});
    v.push_back('{1'b1, 1'b1, 3'b011, MUL,  8'd5,  8'd6,  8'd5,  8'd6,  8'h1E, 2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b000, ADD,  8'd1,  8'd2,  8'd1,  8'd2,  8'd3,  2'b10, 2'b10});
    v.push_back('{1'b1, 1'b1, 3'b111, ADD,  8'd1,  8'd1,  8'd0,  8'd0,  8'd0,  2'b01, 2'b01});
    v.push_back('{1'b1, 1'b1, 3'b000, ADD,  8'd1,  8'd1,  8'd0,  8'd0,  8'd0,  2'b01, 2'b01});
    foreach (v[i]) apply(v[i], i);
    // persist chain with a mid-chain op change, then reset during the chain, then off after reset
    apply('{1'b1, 1'b1, 3'b010, ADD, 8'd5, 8'd0, 8'd5, 8'd0, 8'd5,  2'b10, 2'b10}, 100);
    apply('{1'b1, 1'b1, 3'b001, ADD, 8'd9, 8'd1, 8'd5, 8'd1, 8'd6,  2'b11, 2'b11}, 101);
    apply('{1'b1, 1'b1, 3'b001, SUB, 8'd9, 8'd2, 8'd6, 8'd2, 8'd4,  2'b11, 2'b11}, 102);
    apply('{1'b1, 1'b1, 3'b001, XOR, 8'd9, 8'hFF,8'd4, 8'hFF,8'hFB, 2'b11, 2'b11}, 103);
    apply('{1'b0, 1'b1, 3'b001, ADD, 8'd9, 8'd1, 8'hFB,8'd1, 8'd0,  2'b11, 2'b00}, 104);
    apply('{1'b1, 1'b0, 3'b010, ADD, 8'd9, 8'd1, 8'd0, 8'd0, 8'd0,  2'b00, 2'b00}, 105);
    apply('{1'b1, 1'b1, 3'b001, ADD, 8'd9, 8'd7, 8'd0, 8'd7, 8'd7,  2'b11, 2'b11}, 106);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
